ahb_master_mux2: RTL

//  Two-master AHB-lite front end. Sits directly upstream of the AHB-lite system (bus + slaves).

---
 rtl/ahb_master_mux2_pkg.sv | 18 +
 rtl/ahb_master_mux2_slot.sv | 54 +++++
 rtl/ahb_master_mux2.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ahb_master_mux2_pkg.sv
// Shared constants and types for the two-master AHB-lite front end.
package ahb_master_mux2_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam int unsigned ArbFixed = 0;
    localparam int unsigned ArbRr    = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } ahb_req_t;

endpackage

// File: rtl/ahb_master_mux2_slot.sv
// Per-master request slot: holds one captured address phase until the arbiter grants it.
module ahb_master_mux2_slot
    import ahb_master_mux2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready_m,
    input  logic        grant,
    output logic        pend,
    output logic        req,
    output ahb_req_t    req_info
);

    logic     capture;
    logic     pend_q;
    logic     pend_d;
    ahb_req_t held_q;
    ahb_req_t live;

    assign capture = hready_m & ((htrans == HtransNonseq) | (htrans == HtransSeq));

    always_comb begin
        live       = '0;
        live.addr  = haddr;
        live.write = hwrite;
        live.size  = hsize;
    end

    // A fresh capture competes in the same cycle so an uncontended transfer costs one wait state.
    assign req      = pend_q | capture;
    assign req_info = pend_q ? held_q : live;
    assign pend     = pend_q;

    always_comb begin
        pend_d = req & ~grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            held_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (capture) begin
                held_q <= live;
            end
        end
    end

endmodule

// File: rtl/ahb_master_mux2.sv
// Two-master AHB-lite front end: registers, arbitrates and replays master address phases.
module ahb_master_mux2
    import ahb_master_mux2_pkg::*;
#(
    parameter int unsigned RR_ARB = ArbFixed
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [31:0] HWDATA_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HREADY_M0,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    logic     pend0, pend1;
    logic     req0, req1;
    logic     grant0, grant1;
    logic     prefer0;
    logic     aph0_q, aph1_q, dph0_q, dph1_q;
    logic     prio1_q, prio1_d;
    ahb_req_t info0, info1, win;

    ahb_master_mux2_slot u_slot0 (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .haddr    (HADDR_M0),
        .htrans   (HTRANS_M0),
        .hwrite   (HWRITE_M0),
        .hsize    (HSIZE_M0),
        .hready_m (HREADY_M0),
        .grant    (grant0),
        .pend     (pend0),
        .req      (req0),
        .req_info (info0)
    );

    ahb_master_mux2_slot u_slot1 (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .haddr    (HADDR_M1),
        .htrans   (HTRANS_M1),
        .hwrite   (HWRITE_M1),
        .hsize    (HSIZE_M1),
        .hready_m (HREADY_M1),
        .grant    (grant1),
        .pend     (pend1),
        .req      (req1),
        .req_info (info1)
    );

    assign HREADY_M0 = ~(pend0 | aph0_q | dph0_q) | (dph0_q & HREADY);
    assign HREADY_M1 = ~(pend1 | aph1_q | dph1_q) | (dph1_q & HREADY);
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

    // prio1_q set means M1 wins the next tie; only consulted in round-robin mode.
    always_comb begin
        prefer0 = (RR_ARB == ArbRr) ? ~prio1_q : 1'b1;
        grant0  = HREADY & req0 & (~req1 | prefer0);
        grant1  = HREADY & req1 & ~grant0;
        prio1_d = prio1_q;
        if (grant0) begin
            prio1_d = 1'b1;
        end else if (grant1) begin
            prio1_d = 1'b0;
        end
        win = grant1 ? info1 : info0;
    end

    always_comb begin
        HWDATA = '0;
        if (dph0_q) begin
            HWDATA = HWDATA_M0;
        end else if (dph1_q) begin
            HWDATA = HWDATA_M1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph0_q  <= 1'b0;
            aph1_q  <= 1'b0;
            dph0_q  <= 1'b0;
            dph1_q  <= 1'b0;
            prio1_q <= 1'b0;
            HTRANS  <= HtransIdle;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= '0;
        end else if (HREADY) begin
            dph0_q  <= aph0_q;
            dph1_q  <= aph1_q;
            aph0_q  <= grant0;
            aph1_q  <= grant1;
            prio1_q <= prio1_d;
            // Bursts may be split by arbitration, so every replayed beat is NONSEQ.
            if (grant0 | grant1) begin
                HTRANS <= HtransNonseq;
                HADDR  <= win.addr;
                HWRITE <= win.write;
                HSIZE  <= win.size;
            end else begin
                HTRANS <= HtransIdle;
            end
        end
    end

endmodule
